ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter_if.sv | 37 +++
 rtl/ahb_arbiter.sv | 99 +++++++++
 tb/tb_ahb_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// Arbitration signal bundle shared between the AHB masters and the arbiter.
// The arbiter takes the slave view: it reads requests and bus status and
// drives grant and ownership outputs.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 3
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [1:0]             hmaster;
  logic [1:0]             hmaster_data;
  logic                   hmastlock;

  modport master (
    output hbusreq,
    output hlock,
    output htrans,
    output hready,
    input  hgrant,
    input  hmaster,
    input  hmaster_data,
    input  hmastlock
  );

  modport slave (
    input  hbusreq,
    input  hlock,
    input  htrans,
    input  hready,
    output hgrant,
    output hmaster,
    output hmaster_data,
    output hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with locked-transfer support.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_DEFAULT | nobody requests, DEFAULT_MASTER is parked on the bus
// ST_OWNED   | a requesting master holds the grant
// ST_LOCKED  | the owner runs a locked sequence; other requests ignored
//
// Everything advances only on hready=1 edges so the grant never changes
// while a slave is stretching a transfer. The round-robin pointer is the
// index of the current grant itself, so no separate pending memory exists:
// a request that drops before it is served simply loses its turn.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input logic          hclk,
  input logic          hresetn,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  localparam logic [1:0] DEF_IDX     = 2'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    ST_DEFAULT,
    ST_OWNED,
    ST_LOCKED
  } state_t;

  state_t     state;
  logic [1:0] owner;
  logic       hold;
  logic       next_found;
  logic [1:0] next_idx;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Hold the grant during a burst continuation or an unreleased lock.
  // A lock releases only at an IDLE/NONSEQ boundary, which the burst term
  // already covers.
  always_comb begin
    hold = (bus.htrans == HTRANS_BUSY) || (bus.htrans == HTRANS_SEQ) ||
           ((state == ST_LOCKED) && bus.hlock[owner]);
  end

  // Round-robin pick: scan from owner+1 and wrap so the owner comes last.
  always_comb begin
    logic [1:0] cand;
    int         c;
    next_found = 1'b0;
    next_idx   = DEF_IDX;
    cand       = '0;
    c          = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      c = int'(owner) + k;
      if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      cand = 2'(c);
      if (!next_found && bus.hbusreq[cand]) begin
        next_found = 1'b1;
        next_idx   = cand;
      end
    end
  end

  // Arbitration FSM with registered grant, ownership pipeline and lock flag.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state            <= ST_DEFAULT;
      owner            <= DEF_IDX;
      bus.hgrant       <= onehot(DEF_IDX);
      bus.hmaster      <= DEF_IDX;
      bus.hmaster_data <= DEF_IDX;
      bus.hmastlock    <= 1'b0;
    end else if (bus.hready) begin
      bus.hmaster_data <= bus.hmaster;
      bus.hmaster      <= owner;
      bus.hmastlock    <= bus.hlock[owner];
      if (!hold) begin
        if (next_found) begin
          owner      <= next_idx;
          bus.hgrant <= onehot(next_idx);
          state      <= bus.hlock[next_idx] ? ST_LOCKED : ST_OWNED;
        end else begin
          owner      <= DEF_IDX;
          bus.hgrant <= onehot(DEF_IDX);
          state      <= ST_DEFAULT;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: three masters, default master 0.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic hclk;
  logic hresetn;
  int   n_cmp;
  int   n_mis;

  ahb_arbiter_if #(.NUM_MASTERS(3)) bus ();

  ahb_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] lock,
                       input logic [1:0] trans, input logic rdy);
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.htrans  = trans;
    bus.hready  = rdy;
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int g, input int m,
                         input int d, input int l);
    chk({tag, ".hgrant"},       int'(bus.hgrant),       g);
    chk({tag, ".hmaster"},      int'(bus.hmaster),      m);
    chk({tag, ".hmaster_data"}, int'(bus.hmaster_data), d);
    chk({tag, ".hmastlock"},    int'(bus.hmastlock),    l);
  endtask

  int rr_g[4] = '{2, 4, 2, 4};
  int rr_m[4] = '{0, 1, 2, 1};
  int rr_d[4] = '{0, 0, 1, 2};
  logic [2:0] frz_req[3] = '{3'b010, 3'b100, 3'b110};

  initial begin
    n_cmp = 0;
    n_mis = 0;
    hresetn = 1'b0;
    drive(3'b000, 3'b000, IDLE, 1'b1);
    #12;
    chk_all("rst", 1, 0, 0, 0);
    hresetn = 1'b1;

    // idle bus parks on master 0
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 1, 0, 0, 0);
    end

    // masters 1 and 2 alternate
    drive(3'b110, 3'b000, NONSEQ, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("rr%0d", i), rr_g[i], rr_m[i], rr_d[i], 0);
    end

    // master 1 takes the bus, then holds it through a SEQ burst
    drive(3'b010, 3'b000, NONSEQ, 1'b1);
    step();
    chk("own1.hgrant", int'(bus.hgrant), 2);
    drive(3'b111, 3'b000, SEQ, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("seq%0d.hgrant", i), int'(bus.hgrant), 2);
    end
    drive(3'b111, 3'b000, NONSEQ, 1'b1);
    step();
    chk("seq_end.hgrant", int'(bus.hgrant), 4);

    // locked sequence of master 2
    drive(3'b100, 3'b100, NONSEQ, 1'b1);
    step();
    chk_all("lk0", 4, 2, 1, 1);
    drive(3'b111, 3'b100, NONSEQ, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_all($sformatf("lk%0d", i), 4, 2, 2, 1);
    end
    drive(3'b111, 3'b000, NONSEQ, 1'b1);
    step();
    chk_all("lk_rel", 1, 2, 2, 0);

    // hready low freezes everything while requests wander
    for (int i = 0; i < 3; i++) begin
      drive(frz_req[i], 3'b000, NONSEQ, 1'b0);
      step();
      chk_all($sformatf("frz%0d", i), 1, 2, 2, 0);
    end
    drive(3'b100, 3'b000, NONSEQ, 1'b1);
    step();
    chk_all("resume", 4, 0, 2, 0);

    // no requests falls back to the default master
    drive(3'b000, 3'b000, IDLE, 1'b1);
    step();
    chk_all("dflt", 1, 2, 0, 0);

    // reset in the middle of a locked SEQ burst of master 1
    drive(3'b010, 3'b010, NONSEQ, 1'b1);
    step();
    chk("lk1.hgrant", int'(bus.hgrant), 2);
    drive(3'b010, 3'b010, SEQ, 1'b1);
    step();
    step();
    chk_all("lk1_seq", 2, 1, 1, 1);
    #2;
    hresetn = 1'b0;
    #1;
    chk_all("async_rst", 1, 0, 0, 0);
    #2;
    hresetn = 1'b1;
    drive(3'b010, 3'b000, IDLE, 1'b1);
    step();
    chk_all("post_rst", 2, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
